mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 74 +++++++
 rtl/mem_stage.sv | 183 ++++++++++++++++++
 tb/tb_mem_stage.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_pkg / mem_stage_if
// Purpose : shared bundle types and opcodes for the memory stage, plus the
//           interface that groups every handshake and data-bus signal of it.
// Ports (interface members):
//   m_valid, r_M, m_ready                     Execute -> Memory handshake
//   dreq_valid, dreq_addr, dreq_strobe,
//   dreq_data                                 data-bus request (strobe 0 = read)
//   dresp_addr_ok, dresp_data_ok, dresp_data  data-bus response
//   w_valid, w_ready, r_W, adel, ades         Memory -> Writeback handshake
// Modports: slave = the memory stage, master = its surroundings.
package mem_stage_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  typedef struct packed {
    logic [4:0]  dstE;
    logic [4:0]  dstM;
    logic [31:0] valA;
    logic [31:0] valE;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic        btype;
  } plr_m;

  typedef struct packed {
    logic [4:0]  dstE;
    logic [4:0]  dstM;
    logic [31:0] valE;
    logic [31:0] valM;
    logic [5:0]  opcode;
    logic [31:0] pc;
  } plr_w;

endpackage

interface mem_stage_if;
  logic                  m_valid;
  mem_stage_pkg::plr_m   r_M;
  logic                  m_ready;
  logic                  dreq_valid;
  logic [31:0]           dreq_addr;
  logic [3:0]            dreq_strobe;
  logic [31:0]           dreq_data;
  logic                  dresp_addr_ok;
  logic                  dresp_data_ok;
  logic [31:0]           dresp_data;
  logic                  w_valid;
  logic                  w_ready;
  mem_stage_pkg::plr_w   r_W;
  logic                  adel;
  logic                  ades;

  modport slave (
    input  m_valid, r_M, dresp_addr_ok, dresp_data_ok, dresp_data, w_ready,
    output m_ready, dreq_valid, dreq_addr, dreq_strobe, dreq_data,
           w_valid, r_W, adel, ades
  );

  modport master (
    output m_valid, r_M, dresp_addr_ok, dresp_data_ok, dresp_data, w_ready,
    input  m_ready, dreq_valid, dreq_addr, dreq_strobe, dreq_data,
           w_valid, r_W, adel, ades
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage
// Purpose : pipeline memory stage. Accepts one Execute bundle at a time,
//           performs at most one data-bus access for it (load/store with
//           alignment check, lane steering, load extension) and hands the
//           result to Writeback.
// Ports   : clk   - sole clock, rising edge
//           reset - asynchronous, active-high
//           bus   - mem_stage_if.slave (Execute, data-bus and Writeback sides)
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

  state_t      r_state;
  logic        r_dreq_valid;
  logic [31:0] r_dreq_addr;
  logic [3:0]  r_dreq_strobe;
  logic [31:0] r_dreq_data;
  logic        r_w_valid;
  plr_w        r_W;
  logic        r_adel;
  logic        r_ades;

  plr_m        w_m;
  logic        w_accept;
  logic        w_mis;

  function automatic logic f_is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic f_is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic f_misaligned(input logic [5:0] op, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (op)
      OP_LW, OP_SW:         mis = (lo != 2'b00);
      OP_LH, OP_LHU, OP_SH: mis = lo[0];
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] f_strobe(input logic [5:0] op, input logic [1:0] lo);
    logic [3:0] s;
    s = 4'b0000;
    case (op)
      OP_SW:   s = 4'b1111;
      OP_SH:   s = lo[1] ? 4'b1100 : 4'b0011;
      OP_SB:   s = 4'b0001 << lo;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // Store data is replicated across all lanes so the strobe alone picks bytes.
  function automatic logic [31:0] f_wdata(input logic [5:0] op, input logic [31:0] a);
    logic [31:0] d;
    d = a;
    case (op)
      OP_SH:   d = {2{a[15:0]}};
      OP_SB:   d = {4{a[7:0]}};
      default: d = a;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] f_extract(input logic [5:0] op, input logic [1:0] lo,
                                            input logic [31:0] word);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [31:0] sx;
    logic [31:0]        res;
    b   = 8'(word >> {lo, 3'b000});
    h   = lo[1] ? word[31:16] : word[15:0];
    res = 32'd0;
    case (op)
      OP_LW:  res = word;
      OP_LB:  begin sx = 32'(signed'(b)); res = unsigned'(sx); end
      OP_LBU: res = {24'd0, b};
      OP_LH:  begin sx = 32'(signed'(h)); res = unsigned'(sx); end
      OP_LHU: res = {16'd0, h};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  assign w_m      = bus.r_M;
  assign w_accept = bus.m_valid && (r_state == IDLE);
  assign w_mis    = f_misaligned(w_m.opcode, w_m.valE[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_dreq_valid  <= 1'b0;
      r_dreq_addr   <= '0;
      r_dreq_strobe <= '0;
      r_dreq_data   <= '0;
      r_w_valid     <= 1'b0;
      r_W           <= '0;
      r_adel        <= 1'b0;
      r_ades        <= 1'b0;
    end else begin
      case (r_state)
        // Accept: capture the bundle; decide bus access, exception or bypass.
        IDLE: begin
          if (w_accept) begin
            r_W.dstE   <= w_m.dstE;
            r_W.dstM   <= w_m.dstM;
            r_W.valE   <= w_m.valE;
            r_W.valM   <= '0;
            r_W.opcode <= w_m.opcode;
            r_W.pc     <= w_m.pc;
            if ((f_is_load(w_m.opcode) || f_is_store(w_m.opcode)) && !w_mis) begin
              r_adel        <= 1'b0;
              r_ades        <= 1'b0;
              r_dreq_valid  <= 1'b1;
              r_dreq_addr   <= w_m.valE;
              r_dreq_strobe <= f_strobe(w_m.opcode, w_m.valE[1:0]);
              r_dreq_data   <= f_wdata(w_m.opcode, w_m.valA);
              r_state       <= ADDR;
            end else begin
              r_adel    <= f_is_load(w_m.opcode) && w_mis;
              r_ades    <= f_is_store(w_m.opcode) && w_mis;
              r_w_valid <= 1'b1;
              r_state   <= HOLD;
            end
          end
        end
        // Address phase: request held stable until the bus takes it.
        ADDR: begin
          if (bus.dresp_addr_ok) begin
            r_dreq_valid  <= 1'b0;
            r_dreq_strobe <= '0;
            if (bus.dresp_data_ok) begin
              r_W.valM  <= f_extract(r_W.opcode, r_W.valE[1:0], bus.dresp_data);
              r_w_valid <= 1'b1;
              r_state   <= HOLD;
            end else begin
              r_state <= DATA;
            end
          end
        end
        // Data phase: wait for the response, then extract the load result.
        DATA: begin
          if (bus.dresp_data_ok) begin
            r_W.valM  <= f_extract(r_W.opcode, r_W.valE[1:0], bus.dresp_data);
            r_w_valid <= 1'b1;
            r_state   <= HOLD;
          end
        end
        // Hold: result frozen until Writeback takes it.
        HOLD: begin
          if (bus.w_ready) begin
            r_w_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.m_ready     = (r_state == IDLE);
  assign bus.dreq_valid  = r_dreq_valid;
  assign bus.dreq_addr   = r_dreq_addr;
  assign bus.dreq_strobe = r_dreq_strobe;
  assign bus.dreq_data   = r_dreq_data;
  assign bus.w_valid     = r_w_valid;
  assign bus.r_W         = r_W;
  assign bus.adel        = r_adel;
  assign bus.ades        = r_ades;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// Purpose : directed and randomized transactions through mem_stage, each
//           checked against a byte-level model of loads, stores and alignment.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mem_stage_if bus();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Access size in bytes; 0 means the opcode does not touch memory.
  function automatic int ref_size(input logic [5:0] op);
    if (op == OP_LW || op == OP_SW) return 4;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    return 0;
  endfunction

  function automatic bit ref_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic [31:0] ref_valM(input logic [5:0] op, input int off,
                                           input logic [31:0] word);
    int unsigned v;
    int unsigned span;
    int n;
    n = ref_size(op);
    if (n == 0 || ref_store(op)) return 32'd0;
    if (n == 4) return word;
    span = 32'd1 << (8 * n);
    v    = (word >> (8 * off)) % span;
    if ((op == OP_LB || op == OP_LH) && v >= span / 2) v = v - span;
    return v;
  endfunction

  function automatic logic [3:0] ref_strobe(input logic [5:0] op, input int off);
    logic [3:0] s;
    int n;
    s = 4'b0000;
    n = ref_size(op);
    if (ref_store(op))
      for (int i = 0; i < 4; i++) if (i >= off && i < off + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [5:0] op, input logic [31:0] a);
    logic [31:0] d;
    int n;
    n = ref_size(op);
    d = '0;
    for (int i = 0; i < 4; i++) d[8*i +: 8] = a[8*(i % n) +: 8];
    return d;
  endfunction

  task automatic do_tx(input string tag, input logic [5:0] op, input logic [31:0] vale,
                       input logic [31:0] vala, input logic [31:0] rdata,
                       input int addr_dly, input int data_dly, input int wr_dly);
    plr_m        m;
    int          n;
    int          off;
    bit          mis;
    logic [31:0] exp_valM;
    m.dstE   = 5'($urandom);
    m.dstM   = 5'($urandom);
    m.valA   = vala;
    m.valE   = vale;
    m.opcode = op;
    m.funct  = 6'($urandom);
    m.pc     = $urandom;
    m.btype  = 1'($urandom);
    n        = ref_size(op);
    off      = int'(vale[1:0]);
    mis      = (n != 0) && ((off % n) != 0);
    exp_valM = mis ? 32'd0 : ref_valM(op, off, rdata);

    @(negedge clk);
    check({tag, ".m_ready_idle"}, 128'(bus.m_ready), 128'(1'b1));
    bus.m_valid = 1'b1;
    bus.r_M     = m;
    @(negedge clk);
    bus.m_valid = 1'b0;
    bus.r_M     = plr_m'({$urandom, $urandom, $urandom, $urandom, $urandom});

    if (n != 0 && !mis) begin
      for (int c = 0; c <= addr_dly; c++) begin
        check({tag, ".dreq_valid"}, 128'(bus.dreq_valid), 128'(1'b1));
        check({tag, ".dreq_addr"}, 128'(bus.dreq_addr), 128'(vale));
        check({tag, ".dreq_strobe"}, 128'(bus.dreq_strobe), 128'(ref_strobe(op, off)));
        check({tag, ".m_ready_busy"}, 128'(bus.m_ready), 128'(1'b0));
        if (ref_store(op))
          check({tag, ".dreq_data"}, 128'(bus.dreq_data), 128'(ref_wdata(op, vala)));
        bus.dresp_addr_ok = (c == addr_dly);
        bus.dresp_data_ok = (c == addr_dly) && (data_dly == 0);
        bus.dresp_data    = bus.dresp_data_ok ? rdata : $urandom;
        @(negedge clk);
      end
      bus.dresp_addr_ok = 1'b0;
      bus.dresp_data_ok = 1'b0;
      for (int c = 0; c < data_dly; c++) begin
        check({tag, ".data_dreq_valid"}, 128'(bus.dreq_valid), 128'(1'b0));
        check({tag, ".data_w_valid"}, 128'(bus.w_valid), 128'(1'b0));
        bus.dresp_data_ok = (c == data_dly - 1);
        bus.dresp_data    = bus.dresp_data_ok ? rdata : $urandom;
        @(negedge clk);
      end
      bus.dresp_data_ok = 1'b0;
    end

    for (int c = 0; c <= wr_dly; c++) begin
      check({tag, ".w_valid"}, 128'(bus.w_valid), 128'(1'b1));
      check({tag, ".hold_m_ready"}, 128'(bus.m_ready), 128'(1'b0));
      check({tag, ".hold_dreq_valid"}, 128'(bus.dreq_valid), 128'(1'b0));
      check({tag, ".valM"}, 128'(bus.r_W.valM), 128'(exp_valM));
      check({tag, ".valE"}, 128'(bus.r_W.valE), 128'(vale));
      check({tag, ".pc"}, 128'(bus.r_W.pc), 128'(m.pc));
      check({tag, ".dst"}, 128'({bus.r_W.dstE, bus.r_W.dstM}), 128'({m.dstE, m.dstM}));
      check({tag, ".opcode"}, 128'(bus.r_W.opcode), 128'(op));
      check({tag, ".adel"}, 128'(bus.adel), 128'(mis && !ref_store(op)));
      check({tag, ".ades"}, 128'(bus.ades), 128'(mis && ref_store(op)));
      bus.w_ready = (c == wr_dly);
      @(negedge clk);
    end
    bus.w_ready = 1'b0;
    check({tag, ".w_valid_drop"}, 128'(bus.w_valid), 128'(1'b0));
    check({tag, ".m_ready_back"}, 128'(bus.m_ready), 128'(1'b1));
  endtask

  initial begin
    logic [5:0] ops [10];
    logic [5:0] op;
    logic [31:0] va;
    plr_m mr;
    errors = 0;
    checks = 0;
    ops = '{OP_ADDIU, OP_SPECIAL, OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB};
    reset = 1'b1;
    bus.m_valid = 1'b0;
    bus.r_M = '0;
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    bus.dresp_data = '0;
    bus.w_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst.w_valid", 128'(bus.w_valid), 128'(1'b0));
    check("rst.dreq_valid", 128'(bus.dreq_valid), 128'(1'b0));
    check("rst.dreq_strobe", 128'(bus.dreq_strobe), 128'(4'b0000));
    check("rst.adel_ades", 128'({bus.adel, bus.ades}), 128'(2'b00));
    check("rst.r_W", 128'(bus.r_W), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    check("rst.m_ready", 128'(bus.m_ready), 128'(1'b1));

    do_tx("addiu", OP_ADDIU, 32'h0000_0010, 32'h5555_5555, 32'h0, 0, 0, 0);
    do_tx("lb", OP_LB, 32'h1000_0003, 32'h0, 32'h80FF_FFFF, 0, 0, 0);
    do_tx("lbu", OP_LBU, 32'h1000_0003, 32'h0, 32'h80FF_FFFF, 0, 0, 0);
    do_tx("sh", OP_SH, 32'h1000_0002, 32'h1234_ABCD, 32'h0, 3, 1, 0);
    do_tx("lw_mis", OP_LW, 32'h1000_0002, 32'h0, 32'hCAFE_F00D, 0, 0, 0);
    do_tx("sw_mis", OP_SW, 32'h1000_0001, 32'h0, 32'h0, 0, 0, 1);
    do_tx("lw_wstall", OP_LW, 32'h1000_0008, 32'h0, 32'hCAFE_F00D, 1, 2, 5);
    do_tx("lh", OP_LH, 32'h2000_0002, 32'h0, 32'h9234_0001, 0, 1, 0);
    do_tx("sb", OP_SB, 32'h2000_0001, 32'h0000_00A5, 32'h0, 1, 0, 0);

    // Reset while waiting for data; a later data_ok must be ignored.
    @(negedge clk);
    mr = '0;
    mr.opcode = OP_LW;
    mr.valE = 32'h1000_0004;
    mr.pc = 32'hBFC0_0100;
    bus.m_valid = 1'b1;
    bus.r_M = mr;
    @(negedge clk);
    bus.m_valid = 1'b0;
    check("rdata.dreq_valid", 128'(bus.dreq_valid), 128'(1'b1));
    bus.dresp_addr_ok = 1'b1;
    @(negedge clk);
    bus.dresp_addr_ok = 1'b0;
    check("rdata.in_data", 128'({bus.dreq_valid, bus.w_valid, bus.m_ready}), 128'(3'b000));
    reset = 1'b1;
    #1;
    check("rdata.async_idle", 128'({bus.dreq_valid, bus.w_valid, bus.m_ready}), 128'(3'b001));
    check("rdata.async_r_W", 128'(bus.r_W), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    bus.dresp_data_ok = 1'b1;
    bus.dresp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.dresp_data_ok = 1'b0;
    check("rdata.stray_w_valid", 128'(bus.w_valid), 128'(1'b0));
    check("rdata.stray_r_W", 128'(bus.r_W), 128'(0));
    check("rdata.stray_m_ready", 128'(bus.m_ready), 128'(1'b1));

    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 9)];
      va = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (ref_size(op) == 4) va[1:0] = 2'b00;
        if (ref_size(op) == 2) va[0] = 1'b0;
      end
      do_tx("rand", op, va, $urandom, $urandom, $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
